// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between Fetch (IF) and Memory (DM) stages with starvation guard and flush discard.
// Define ARB_PERF_EN to add free-running stall and forced-grant performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic [DATA_W-1:0]     if_rdata_o,
    output logic                  if_valid_o,
    output logic                  if_stall_o,
    input  logic                  flush_i,
    input  logic                  dm_req_i,
    input  logic                  dm_we_i,
    input  logic [ADDR_W-1:0]     dm_addr_i,
    input  logic [DATA_W-1:0]     dm_wdata_i,
    input  logic [DATA_W/8-1:0]   dm_be_i,
    output logic [DATA_W-1:0]     dm_rdata_o,
    output logic                  dm_valid_o,
    output logic                  dm_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_be_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_W-1:0]     mem_rdata_i
`ifdef ARB_PERF_EN
    ,
    output logic [31:0]           perf_if_stall_o,
    output logic [31:0]           perf_dm_stall_o,
    output logic [7:0]            perf_starve_o
`endif
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        state_q, state_d;
    logic              own_dm_q, own_dm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic              we_q, we_d;
    logic [3:0]        starve_q, starve_d;
    logic              discard_q, discard_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    // A fetch presented alongside a flush belongs to the squashed path.
    logic if_elig, force_if;
    assign if_elig  = if_req_i & ~flush_i;
    assign force_if = if_elig & (starve_q == STARVE_LIM);

    always_comb begin
        // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
        state_d    = state_q;
        own_dm_d   = own_dm_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        starve_d   = starve_q;
        discard_d  = discard_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (dm_req_i && !force_if) begin
                    own_dm_d = 1'b1;
                    addr_d   = dm_addr_i;
                    wdata_d  = dm_wdata_i;
                    be_d     = dm_be_i;
                    we_d     = dm_we_i;
                    state_d  = S_REQ;
                    if (!if_req_i) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_LIM) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_elig) begin
                    own_dm_d = 1'b0;
                    addr_d   = if_addr_i;
                    wdata_d  = '0;
                    be_d     = '1;
                    we_d     = 1'b0;
                    starve_d = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (flush_i && !own_dm_q) discard_d = 1'b1;
                if (mem_gnt_i) state_d = we_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (flush_i && !own_dm_q) discard_d = 1'b1;
                if (mem_rvalid_i) begin
                    if (own_dm_q) dm_rdata_d = mem_rdata_i;
                    else          if_rdata_d = mem_rdata_i;
                    state_d = S_DONE;
                end
            end
            default: begin
                discard_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            own_dm_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            starve_q   <= '0;
            discard_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            // NOTE: non-blocking updates let every register see pre-edge values regardless of statement order.
            state_q    <= state_d;
            own_dm_q   <= own_dm_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            starve_q   <= starve_d;
            discard_q  <= discard_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // A flush landing in DONE still suppresses the fetch pulse.
    assign if_valid_o  = (state_q == S_DONE) & ~own_dm_q & ~discard_q & ~flush_i;
    assign dm_valid_o  = (state_q == S_DONE) & own_dm_q;
    assign if_stall_o  = if_req_i & ~if_valid_o;
    assign dm_stall_o  = dm_req_i & ~dm_valid_o;
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;

`ifdef ARB_PERF_EN
    logic [31:0] perf_if_stall_q, perf_dm_stall_q;
    logic [7:0]  perf_starve_q;
    logic        forced_grant;
    assign forced_grant = (state_q == S_IDLE) & force_if & dm_req_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_stall_q <= '0;
            perf_dm_stall_q <= '0;
            perf_starve_q   <= '0;
        end else begin
            if (if_stall_o)   perf_if_stall_q <= perf_if_stall_q + 32'd1;
            if (dm_stall_o)   perf_dm_stall_q <= perf_dm_stall_q + 32'd1;
            if (forced_grant) perf_starve_q   <= perf_starve_q + 8'd1;
        end
    end

    assign perf_if_stall_o = perf_if_stall_q;
    assign perf_dm_stall_o = perf_dm_stall_q;
    assign perf_starve_o   = perf_starve_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester queues, a simple memory responder, and expected grant/data queues.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_valid_o, if_stall_o;
    logic        flush_i = 1'b0;
    logic        dm_req_i = 1'b0;
    logic        dm_we_i = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_wdata_i = '0;
    logic [3:0]  dm_be_i = '0;
    logic [31:0] dm_rdata_o;
    logic        dm_valid_o, dm_stall_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
`ifdef ARB_PERF_EN
    logic [31:0] perf_if_stall, perf_dm_stall;
    logic [7:0]  perf_starve;
`endif

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_valid_o(if_valid_o), .if_stall_o(if_stall_o), .flush_i(flush_i),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i), .dm_rdata_o(dm_rdata_o),
        .dm_valid_o(dm_valid_o), .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
`ifdef ARB_PERF_EN
        ,
        .perf_if_stall_o(perf_if_stall), .perf_dm_stall_o(perf_dm_stall),
        .perf_starve_o(perf_starve)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dm_op_t;

    logic [31:0] if_pend[$];
    logic [31:0] if_exp[$];
    dm_op_t      dm_pend[$];
    logic [31:0] dm_exp[$];
    logic [31:0] gnt_exp[$];
    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] ref_arr [logic [31:0]];

    int n_cmp = 0, n_err = 0, cyc = 0;
    int gnt_cyc = -1, if_valid_cyc = -1, dm_valid_cyc = -1, if_pulses = 0;
    int gnt_delay = 0, wait_cnt = 0;
    logic        rd_due = 1'b0, stray_rvalid = 1'b0, flush_req = 1'b0;
    logic [31:0] rd_addr = '0;

    function automatic logic [31:0] fill(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] be);
        logic [31:0] r = old_v;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_arr.exists(a) ? ref_arr[a] : fill(a);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : fill(a);
    endfunction

    task automatic push_fetch(input logic [31:0] a);
        if_pend.push_back(a);
        if_exp.push_back(ref_rd(a));
    endtask

    task automatic push_load(input logic [31:0] a);
        dm_op_t op;
        op.we = 1'b0; op.addr = a; op.wdata = '0; op.be = 4'hF;
        dm_pend.push_back(op);
        dm_exp.push_back(ref_rd(a));
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        dm_op_t op;
        op.we = 1'b1; op.addr = a; op.wdata = d; op.be = be;
        dm_pend.push_back(op);
        ref_arr[a] = merge(ref_rd(a), d, be);
    endtask

    task automatic drive_inputs();
        flush_i = flush_req;
        if (flush_req && if_pend.size() != 0) begin
            void'(if_pend.pop_front());
            void'(if_exp.pop_front());
        end
        flush_req = 1'b0;
        if_req_i  = (if_pend.size() != 0);
        if_addr_i = if_req_i ? if_pend[0] : 32'h0;
        dm_req_i  = (dm_pend.size() != 0);
        if (dm_req_i) begin
            dm_we_i = dm_pend[0].we; dm_addr_i = dm_pend[0].addr;
            dm_wdata_i = dm_pend[0].wdata; dm_be_i = dm_pend[0].be;
        end else begin
            dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;
        end
    endtask

    task automatic mem_respond();
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b0;
        if (stray_rvalid) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF; stray_rvalid = 1'b0;
        end else if (rd_due) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = mem_rd(rd_addr); rd_due = 1'b0;
        end
        if (mem_req_o) begin
            if (wait_cnt < gnt_delay) begin
                wait_cnt++;
            end else begin
                wait_cnt  = 0;
                mem_gnt_i = 1'b1;
                if (mem_we_o) mem_arr[mem_addr_o] = merge(mem_rd(mem_addr_o), mem_wdata_o, mem_be_o);
                else begin rd_due = 1'b1; rd_addr = mem_addr_o; end
            end
        end
    endtask

    task automatic observe();
        logic [31:0] exp_d;
        dm_op_t      op;
        if (mem_req_o && mem_gnt_i) begin
            gnt_cyc = cyc;
            n_cmp++;
            if (gnt_exp.size() == 0) begin
                n_err++;
                $display("FAIL grant_unexpected: granted addr %08h at cycle %0d, required no grant", mem_addr_o, cyc);
            end else begin
                exp_d = gnt_exp.pop_front();
                if (mem_addr_o !== exp_d) begin
                    n_err++;
                    $display("FAIL grant_order: granted addr %08h, required %08h", mem_addr_o, exp_d);
                end
            end
        end
        if (if_valid_o) begin
            if_valid_cyc = cyc;
            if_pulses++;
            n_cmp++;
            if (if_exp.size() == 0) begin
                n_err++;
                $display("FAIL if_valid_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                exp_d = if_exp.pop_front();
                void'(if_pend.pop_front());
                if (if_rdata_o !== exp_d) begin
                    n_err++;
                    $display("FAIL if_rdata: got %08h, required %08h", if_rdata_o, exp_d);
                end
            end
        end
        if (dm_valid_o) begin
            dm_valid_cyc = cyc;
            n_cmp++;
            if (dm_pend.size() == 0) begin
                n_err++;
                $display("FAIL dm_valid_unexpected: pulse at cycle %0d, required none", cyc);
            end else begin
                op = dm_pend.pop_front();
                if (!op.we) begin
                    exp_d = dm_exp.pop_front();
                    if (dm_rdata_o !== exp_d) begin
                        n_err++;
                        $display("FAIL dm_rdata: got %08h, required %08h", dm_rdata_o, exp_d);
                    end
                end
            end
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
        mem_respond();
        @(negedge clk);
        observe();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n = 0;
        while ((if_pend.size() != 0 || dm_pend.size() != 0) && n < budget) begin
            run_cycle();
            n++;
        end
        if (if_pend.size() != 0 || dm_pend.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: %0d requests outstanding after %0d cycles, required 0",
                     name, if_pend.size() + dm_pend.size(), budget);
            if_pend.delete(); if_exp.delete(); dm_pend.delete(); dm_exp.delete();
        end
        n_cmp++;
        if (gnt_exp.size() != 0) begin
            n_err++;
            $display("FAIL %s_grants_missing: %0d grants never seen, required 0", name, gnt_exp.size());
            gnt_exp.delete();
        end
    endtask

    task automatic wait_grant(input int budget, input string name);
        logic got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            run_cycle();
            got = (gnt_cyc == cyc);
        end
        n_cmp++;
        if (!got) begin
            n_err++;
            $display("FAIL %s_no_grant: no grant within %0d cycles, required one", name, budget);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, if_valid_o, if_stall_o,
             dm_valid_o, dm_stall_o, if_rdata_o, dm_rdata_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: req=%b valid=%b/%b addr=%08h, required all 0",
                     mem_req_o, if_valid_o, dm_valid_o, mem_addr_o);
        end
        rst = 1'b0;
        run_cycle();
        run_cycle();
        n_cmp++;
        if ({mem_req_o, if_valid_o, dm_valid_o} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_idle: req/ifv/dmv=%b%b%b, required 000", mem_req_o, if_valid_o, dm_valid_o);
        end
    endtask

    task automatic test_if_read();
        logic exp_s, exp_v;
        mem_arr[32'h10] = 32'h0070_0093;
        ref_arr[32'h10] = 32'h0070_0093;
        push_fetch(32'h10);
        gnt_exp.push_back(32'h10);
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            exp_s = (i < 3);
            exp_v = (i == 3);
            n_cmp++;
            if (if_stall_o !== exp_s) begin
                n_err++;
                $display("FAIL if_read_stall: cycle %0d got %b, required %b", i, if_stall_o, exp_s);
            end
            n_cmp++;
            if (if_valid_o !== exp_v) begin
                n_err++;
                $display("FAIL if_read_valid: cycle %0d got %b, required %b", i, if_valid_o, exp_v);
            end
        end
        run_until_idle(10, "if_read");
    endtask

    task automatic test_same_cycle();
        int start;
        push_store(32'h100, 32'h0000_00C8, 4'hF);
        push_fetch(32'h20);
        gnt_exp.push_back(32'h100);
        gnt_exp.push_back(32'h20);
        start = cyc + 1;
        run_until_idle(30, "same_cycle");
        n_cmp++;
        if (dm_valid_cyc - start != 2) begin
            n_err++;
            $display("FAIL store_latency: dm_valid at cycle %0d, required 2", dm_valid_cyc - start);
        end
        n_cmp++;
        if (if_valid_cyc <= dm_valid_cyc) begin
            n_err++;
            $display("FAIL store_first: if_valid cycle %0d, required after %0d", if_valid_cyc, dm_valid_cyc);
        end
        n_cmp++;
        if (dm_rdata_o !== 32'h0) begin
            n_err++;
            $display("FAIL dm_rdata_hold: got %08h after store, required 00000000", dm_rdata_o);
        end
    endtask

    task automatic test_gnt_stall();
        int  req_cycles = 0;
        logic got = 1'b0;
        push_load(32'h200);
        gnt_exp.push_back(32'h200);
        gnt_delay = 5;
        for (int k = 0; k < 20 && !got; k++) begin
            run_cycle();
            if (mem_req_o) begin
                got = mem_gnt_i;
                if (!mem_gnt_i) req_cycles++;
                n_cmp++;
                if ({mem_we_o, mem_addr_o, mem_be_o, dm_stall_o} !== {1'b0, 32'h200, 4'hF, 1'b1}) begin
                    n_err++;
                    $display("FAIL gnt_stall_fields: we=%b addr=%08h be=%h stall=%b, required 0/00000200/f/1",
                             mem_we_o, mem_addr_o, mem_be_o, dm_stall_o);
                end
            end
        end
        gnt_delay = 0;
        n_cmp++;
        if (req_cycles != 5) begin
            n_err++;
            $display("FAIL gnt_stall_cycles: %0d waiting cycles, required 5", req_cycles);
        end
        run_until_idle(20, "gnt_stall");
    endtask

    task automatic test_reset_mid();
        push_fetch(32'h300);
        gnt_exp.push_back(32'h300);
        wait_grant(10, "reset_mid");
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1;
        if_pend.delete(); if_exp.delete();
        drive_inputs();
        rd_due = 1'b0; wait_cnt = 0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_be_o, if_valid_o, if_stall_o, dm_valid_o,
             dm_stall_o, if_rdata_o, dm_rdata_o} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: req=%b addr=%08h ifv=%b rdata=%08h, required all 0",
                     mem_req_o, mem_addr_o, if_valid_o, if_rdata_o);
        end
        rst = 1'b0;
        stray_rvalid = 1'b1;
        run_cycle();
        run_cycle();
        n_cmp++;
        if ({mem_req_o, if_valid_o, dm_valid_o, if_rdata_o} !== '0) begin
            n_err++;
            $display("FAIL stray_rvalid: req=%b ifv=%b dmv=%b if_rdata=%08h, required all 0",
                     mem_req_o, if_valid_o, dm_valid_o, if_rdata_o);
        end
    endtask

    task automatic test_starvation();
        push_fetch(32'h40);
        push_load(32'h100);
        push_load(32'h104);
        push_load(32'h108);
        push_load(32'h10C);
        gnt_exp.push_back(32'h100);
        gnt_exp.push_back(32'h104);
        gnt_exp.push_back(32'h108);
        gnt_exp.push_back(32'h40);
        gnt_exp.push_back(32'h10C);
        run_until_idle(80, "starvation");
    endtask

    task automatic test_flush();
        int pulses0;
        push_fetch(32'h80);
        gnt_exp.push_back(32'h80);
        gnt_exp.push_back(32'h84);
        wait_grant(10, "flush");
        flush_req = 1'b1;
        push_fetch(32'h84);
        pulses0 = if_pulses;
        run_until_idle(30, "flush");
        n_cmp++;
        if (if_pulses - pulses0 != 1) begin
            n_err++;
            $display("FAIL flush_pulses: %0d if_valid pulses, required 1", if_pulses - pulses0);
        end
    endtask

    initial begin
        test_reset();
        test_if_read();
        test_same_cycle();
        test_gnt_stall();
        test_reset_mid();
        test_starvation();
        test_flush();
`ifdef ARB_PERF_EN
        n_cmp++;
        if (perf_starve !== 8'd1) begin
            n_err++;
            $display("FAIL perf_starve: got %0d, required 1", perf_starve);
        end
`endif
        run_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
